// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan back end: active-low patterns and position indices.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_ERR   = 8'h86;
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;

    localparam int NUM_POS   = 5;
    localparam int SIGN_IDX  = 0;
    localparam int UNITS_IDX = 4;

endpackage

// File: rtl/seg_decode.sv
// BCD nibble to active-low 7-segment pattern, dp off; combinational, no backpressure.
// Codes A..F have no digit and are shown as 'E'.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] seg
);

    always_comb begin
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_ERR;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// Multiplexes sign + 4 BCD digits onto a common-anode display; outputs registered 1 cycle after scan state.
// Free-running scan, no backpressure; inputs are sampled once per frame at the units->sign boundary.
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int BLANK_CYC   = 16,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic        IN_clk,
    input  logic        IN_rst,
    input  logic [15:0] IN_dec,
    input  logic        IN_neg,
    input  logic [2:0]  IN_off_number,
    output logic [4:0]  OUT_sel,
    output logic [7:0]  OUT_seg,
    output logic        OUT_frame
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] prescaler;
    logic [2:0]    idx;
    logic [15:0]   snap_dec;
    logic          snap_neg;
    logic [2:0]    snap_off;
    logic          tick;
    logic          frame_end;

    logic [3:0]    nib;
    logic [7:0]    nib_seg;
    logic          lead_zero;
    logic          off_blank;
    logic [4:0]    sel_nxt;
    logic [7:0]    seg_nxt;

    assign tick      = (prescaler == PW'(SCAN_DIV - 1));
    assign frame_end = tick && (idx == 3'(UNITS_IDX));

    always_ff @(posedge IN_clk) begin
        if (IN_rst) begin
            prescaler <= '0;
            idx       <= '0;
            snap_dec  <= '0;
            snap_neg  <= 1'b0;
            snap_off  <= '0;
        end else if (tick) begin
            prescaler <= '0;
            // Any out-of-range index falls back to the sign slot.
            idx       <= (idx >= 3'(NUM_POS - 1)) ? 3'd0 : idx + 3'd1;
            if (frame_end) begin
                snap_dec <= IN_dec;
                snap_neg <= IN_neg;
                snap_off <= IN_off_number;
            end
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_comb begin
        case (idx)
            3'd1:    nib = snap_dec[15:12];
            3'd2:    nib = snap_dec[11:8];
            3'd3:    nib = snap_dec[7:4];
            default: nib = snap_dec[3:0];
        endcase
    end

    // A digit is a leading zero when it and everything above it are zero; units never qualifies.
    always_comb begin
        case (idx)
            3'd1:    lead_zero = (snap_dec[15:12] == 4'd0);
            3'd2:    lead_zero = (snap_dec[15:8] == 8'd0);
            3'd3:    lead_zero = (snap_dec[15:4] == 12'd0);
            default: lead_zero = 1'b0;
        endcase
    end

    assign off_blank = ((idx - 3'd1) < snap_off);

    seg_decode u_decode (
        .nib (nib),
        .seg (nib_seg)
    );

    always_comb begin
        sel_nxt = 5'h1F;
        seg_nxt = SEG_BLANK;
        if (prescaler >= PW'(BLANK_CYC)) begin
            sel_nxt = ~(5'd1 << idx);
            if (idx == 3'(SIGN_IDX)) begin
                seg_nxt = snap_neg ? SEG_MINUS : SEG_BLANK;
            end else if (idx <= 3'(UNITS_IDX)) begin
                if (off_blank)
                    seg_nxt = SEG_BLANK;
                else if ((LZ_SUPPRESS != 0) && lead_zero)
                    seg_nxt = SEG_BLANK;
                else
                    seg_nxt = nib_seg;
            end
        end
    end

    always_ff @(posedge IN_clk) begin
        if (IN_rst) begin
            OUT_sel   <= 5'h1F;
            OUT_seg   <= SEG_BLANK;
            OUT_frame <= 1'b0;
        end else begin
            OUT_sel   <= sel_nxt;
            OUT_seg   <= seg_nxt;
            OUT_frame <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: two instances (leading-zero suppression on/off) against a frame-level model.
module tb_seg_scan;

    localparam int SD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] dec = 16'h0;
    logic        neg = 1'b0;
    logic [2:0]  off = 3'd0;

    logic [4:0]  sel1, sel0;
    logic [7:0]  seg1, seg0;
    logic        fr1, fr0;

    int chk  = 0;
    int pass = 0;

    always #5 clk = ~clk;

    seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_SUPPRESS(1)) dut (
        .IN_clk(clk), .IN_rst(rst), .IN_dec(dec), .IN_neg(neg), .IN_off_number(off),
        .OUT_sel(sel1), .OUT_seg(seg1), .OUT_frame(fr1)
    );

    seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_SUPPRESS(0)) dut0 (
        .IN_clk(clk), .IN_rst(rst), .IN_dec(dec), .IN_neg(neg), .IN_off_number(off),
        .OUT_sel(sel0), .OUT_seg(seg0), .OUT_frame(fr0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] digit_pat(input logic [3:0] n);
        case (n)
            4'd0: return 8'hC0;  4'd1: return 8'hF9;  4'd2: return 8'hA4;
            4'd3: return 8'hB0;  4'd4: return 8'h99;  4'd5: return 8'h92;
            4'd6: return 8'h82;  4'd7: return 8'hF8;  4'd8: return 8'h80;
            4'd9: return 8'h90;  default: return 8'h86;
        endcase
    endfunction

    // What position pos shows for a given captured operand.
    function automatic logic [7:0] pos_pat(input int pos, input logic [15:0] d, input logic n,
                                           input logic [2:0] o, input bit lz);
        int sh;
        if (pos == 0) return n ? 8'hBF : 8'hFF;
        if ((pos - 1) < int'(o)) return 8'hFF;
        sh = 4 * (4 - pos);
        if (lz && pos < 4 && ((d >> sh) == 16'h0)) return 8'hFF;
        return digit_pat(4'((d >> sh) & 16'hF));
    endfunction

    // Model: time since reset decides slot and phase; snapshot taken on the last cycle of a frame.
    int          cnt;
    int          mp, mi;
    logic [15:0] m_dec;
    logic        m_neg;
    logic [2:0]  m_off;
    bit          mvalid = 0;
    logic [4:0]  e_sel;
    logic [7:0]  e_seg1, e_seg0;
    logic        e_fr;

    always @(posedge clk) begin
        if (rst) begin
            cnt = 0; m_dec = 16'h0; m_neg = 1'b0; m_off = 3'd0;
            e_sel = 5'h1F; e_seg1 = 8'hFF; e_seg0 = 8'hFF; e_fr = 1'b0;
            mvalid = 1;
        end else begin
            mp = cnt % SD;
            mi = (cnt / SD) % 5;
            if (mp < BC) begin
                e_sel = 5'h1F; e_seg1 = 8'hFF; e_seg0 = 8'hFF;
            end else begin
                e_sel  = 5'h1F ^ (5'd1 << mi);
                e_seg1 = pos_pat(mi, m_dec, m_neg, m_off, 1'b1);
                e_seg0 = pos_pat(mi, m_dec, m_neg, m_off, 1'b0);
            end
            e_fr = (mp == SD - 1) && (mi == 4);
            if (e_fr) begin
                m_dec = dec; m_neg = neg; m_off = off;
            end
            cnt++;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            check("cyc_sel_lz1", sel1, e_sel);
            check("cyc_seg_lz1", seg1, e_seg1);
            check("cyc_frame_lz1", fr1, e_fr);
            check("cyc_sel_lz0", sel0, e_sel);
            check("cyc_seg_lz0", seg0, e_seg0);
            check("cyc_frame_lz0", fr0, e_fr);
        end
    end

    task automatic wait_frame();
        bit ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (fr1) begin ok = 1; break; end
        end
        chk++;
        if (ok) pass++;
        else $display("FAIL frame_wait: no OUT_frame pulse within 100 cycles, required 1");
    endtask

    // Called at the negedge where the frame (or reset release) starts; checks one blank and one lit cycle per slot.
    task automatic slots(input logic [39:0] exp1, input logic [39:0] exp0,
                         input bit chg, input logic [15:0] new_dec);
        int cur = 0;
        for (int k = 0; k < 5; k++) begin
            repeat (8 * k + 2 - cur) @(negedge clk);
            cur = 8 * k + 2;
            check($sformatf("slot%0d_blank_sel", k), sel1, 5'h1F);
            repeat (8 * k + 5 - cur) @(negedge clk);
            cur = 8 * k + 5;
            check($sformatf("slot%0d_sel", k), sel1, 5'h1F ^ (5'd1 << k));
            check($sformatf("slot%0d_seg_lz1", k), seg1, exp1[39 - 8 * k -: 8]);
            check($sformatf("slot%0d_seg_lz0", k), seg0, exp0[39 - 8 * k -: 8]);
            if (chg && k == 2) dec = new_dec;
        end
    endtask

    logic [15:0] rd;

    initial begin
        // Reset held with arbitrary inputs.
        rst = 1'b1; dec = 16'h9876; neg = 1'b1; off = 3'd3;
        repeat (5) begin
            @(negedge clk);
            check("rst_sel", sel1, 5'h1F);
            check("rst_seg", seg1, 8'hFF);
            check("rst_frame", fr1, 1'b0);
        end
        rst = 1'b0; dec = 16'h1234; neg = 1'b0; off = 3'd0;
        slots(40'hFF_FF_FF_FF_C0, 40'hFF_C0_C0_C0_C0, 0, 16'h0);

        wait_frame();
        slots(40'hFF_F9_A4_B0_99, 40'hFF_F9_A4_B0_99, 0, 16'h0);

        dec = 16'h0045; neg = 1'b1;
        wait_frame();
        slots(40'hBF_FF_FF_99_92, 40'hBF_C0_C0_99_92, 0, 16'h0);

        dec = 16'h1234; neg = 1'b0; off = 3'd2;
        wait_frame();
        slots(40'hFF_FF_FF_B0_99, 40'hFF_FF_FF_B0_99, 0, 16'h0);

        off = 3'd6;
        wait_frame();
        slots(40'hFF_FF_FF_FF_FF, 40'hFF_FF_FF_FF_FF, 0, 16'h0);

        // Mid-frame input change must not disturb the frame on screen.
        off = 3'd0;
        wait_frame();
        slots(40'hFF_F9_A4_B0_99, 40'hFF_F9_A4_B0_99, 1, 16'h5678);
        wait_frame();
        slots(40'hFF_92_82_F8_80, 40'hFF_92_82_F8_80, 0, 16'h0);

        dec = 16'h00A0;
        wait_frame();
        slots(40'hFF_FF_FF_86_C0, 40'hFF_C0_C0_86_C0, 0, 16'h0);

        // Reset in the middle of the tens slot.
        wait_frame();
        repeat (29) @(negedge clk);
        check("pre_rst_sel", sel1, 5'h17);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_sel", sel1, 5'h1F);
        check("midrst_seg", seg1, 8'hFF);
        check("midrst_frame", fr1, 1'b0);
        rst = 1'b0;
        slots(40'hFF_FF_FF_FF_C0, 40'hFF_C0_C0_C0_C0, 0, 16'h0);

        // Randomized operands, timing and occasional resets, covered by the per-cycle model.
        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 1) == 1)
                rd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                      4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            else
                rd = 16'($urandom);
            if ($urandom_range(0, 1) == 1) rd = rd >> (4 * $urandom_range(0, 3));
            dec = rd;
            neg = 1'($urandom_range(0, 1));
            off = 3'($urandom_range(0, 7));
            repeat ($urandom_range(1, 60)) @(negedge clk);
            if (r % 10 == 9) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
